// File: rtl/arm_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : arm_alu_seq
// Description : Registered ARM ALU with an iterative shift-add multiplier
//               (MUL/MLA) and an internal NZCV flag register. Operations are
//               launched with start; single-cycle ops finish one edge later,
//               multiplies W+1 edges later. done pulses when result/flags
//               have been updated.
// Ports       : clk       - rising-edge clock
//               reset     - asynchronous active-high reset
//               start     - request (ignored while busy)
//               op        - 5-bit opcode, captured with start
//               a, b, acc - operands (acc used by MLA), captured with start
//               s         - set-flags request, captured with start
//               flags_wr  - direct NZCV load from flags_in (has priority)
//               flags_in  - NZCV value for flags_wr
//               busy      - multiply in progress
//               done      - one-cycle completion pulse
//               result    - last result, held between operations
//               result_we - write-back enable, meaningful with done
//               flags     - registered NZCV (bit3 N .. bit0 V)
// Revision    : 1.0 - initial release
// ============================================================================
module arm_alu_seq #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [4:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] acc,
  input  logic         s,
  input  logic         flags_wr,
  input  logic [3:0]   flags_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         result_we,
  output logic [3:0]   flags
);

  localparam int CW = $clog2(W + 1);

  localparam logic [4:0] c_OP_AND = 5'b00000;
  localparam logic [4:0] c_OP_EOR = 5'b00001;
  localparam logic [4:0] c_OP_SUB = 5'b00010;
  localparam logic [4:0] c_OP_RSB = 5'b00011;
  localparam logic [4:0] c_OP_ADD = 5'b00100;
  localparam logic [4:0] c_OP_ADC = 5'b00101;
  localparam logic [4:0] c_OP_SBC = 5'b00110;
  localparam logic [4:0] c_OP_RSC = 5'b00111;
  localparam logic [4:0] c_OP_TST = 5'b01000;
  localparam logic [4:0] c_OP_TEQ = 5'b01001;
  localparam logic [4:0] c_OP_CMP = 5'b01010;
  localparam logic [4:0] c_OP_CMN = 5'b01011;
  localparam logic [4:0] c_OP_ORR = 5'b01100;
  localparam logic [4:0] c_OP_MOV = 5'b01101;
  localparam logic [4:0] c_OP_BIC = 5'b01110;
  localparam logic [4:0] c_OP_MVN = 5'b01111;
  localparam logic [4:0] c_OP_BYP = 5'b10000;
  localparam logic [4:0] c_OP_INC = 5'b10001;
  localparam logic [4:0] c_OP_MUL = 5'b10010;
  localparam logic [4:0] c_OP_MLA = 5'b10011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [3:0]      r_flags;
  logic [W-1:0]    r_result;
  logic            r_result_we;
  logic [W-1:0]    r_product;
  logic [W-1:0]    r_mcand;
  logic [W-1:0]    r_mplier;
  logic [CW-1:0]   r_cnt;
  logic            r_s;

  // Single-cycle ALU: every add/subtract form is folded into x + y + cin
  // (subtraction as x + ~y + 1, so the carry out is ARM's NOT-borrow).
  logic [W-1:0]    w_x;
  logic [W-1:0]    w_y;
  logic            w_cin;
  logic [W-1:0]    w_logic;
  logic            w_is_arith;
  logic            w_known;
  logic            w_test;
  logic [W:0]      w_sum;
  logic [W-1:0]    w_alu_res;
  logic            w_alu_c;
  logic            w_alu_v;
  logic [3:0]      w_alu_flags;
  logic            w_alu_setf;
  logic            w_is_mul;
  logic [W-1:0]    w_prod_nxt;
  logic            w_mul_last;

  always_comb begin
    w_x        = '0;
    w_y        = '0;
    w_cin      = 1'b0;
    w_logic    = b;
    w_is_arith = 1'b0;
    w_known    = 1'b1;
    w_test     = 1'b0;
    case (op)
      c_OP_AND: w_logic = a & b;
      c_OP_TST: begin w_logic = a & b; w_test = 1'b1; end
      c_OP_EOR: w_logic = a ^ b;
      c_OP_TEQ: begin w_logic = a ^ b; w_test = 1'b1; end
      c_OP_SUB: begin w_x = a; w_y = ~b; w_cin = 1'b1; w_is_arith = 1'b1; end
      c_OP_CMP: begin w_x = a; w_y = ~b; w_cin = 1'b1; w_is_arith = 1'b1; w_test = 1'b1; end
      c_OP_RSB: begin w_x = b; w_y = ~a; w_cin = 1'b1; w_is_arith = 1'b1; end
      c_OP_ADD: begin w_x = a; w_y = b; w_is_arith = 1'b1; end
      c_OP_CMN: begin w_x = a; w_y = b; w_is_arith = 1'b1; w_test = 1'b1; end
      c_OP_ADC: begin w_x = a; w_y = b; w_cin = r_flags[1]; w_is_arith = 1'b1; end
      c_OP_SBC: begin w_x = a; w_y = ~b; w_cin = r_flags[1]; w_is_arith = 1'b1; end
      c_OP_RSC: begin w_x = b; w_y = ~a; w_cin = r_flags[1]; w_is_arith = 1'b1; end
      c_OP_ORR: w_logic = a | b;
      c_OP_MOV: w_logic = b;
      c_OP_BIC: w_logic = a & ~b;
      c_OP_MVN: w_logic = ~b;
      c_OP_BYP: w_logic = b;
      c_OP_INC: begin w_x = a; w_y = W'(1); w_is_arith = 1'b1; end
      // Unassigned opcodes pass b through and never touch the flags.
      default:  begin w_logic = b; w_known = 1'b0; end
    endcase
  end

  assign w_sum       = {1'b0, w_x} + {1'b0, w_y} + {{W{1'b0}}, w_cin};
  assign w_alu_res   = w_is_arith ? w_sum[W-1:0] : w_logic;
  assign w_alu_c     = w_is_arith ? w_sum[W] : r_flags[1];
  assign w_alu_v     = w_is_arith ? ((w_x[W-1] == w_y[W-1]) && (w_sum[W-1] != w_x[W-1]))
                                  : r_flags[0];
  assign w_alu_flags = {w_alu_res[W-1], (w_alu_res == '0), w_alu_c, w_alu_v};
  assign w_alu_setf  = w_known & (s | w_test);
  assign w_is_mul    = (op == c_OP_MUL) || (op == c_OP_MLA);

  // One shift-add step; the step that drives the counter to zero is the
  // last one and its sum is the final product.
  assign w_prod_nxt  = r_mplier[0] ? (r_product + r_mcand) : r_product;
  assign w_mul_last  = (r_cnt == CW'(1));

  // --------------------------------------------------------------------------
  // FSM: state register and next-state / status decode
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_MUL: begin
        busy = 1'b1;
        if (w_mul_last) w_state_nxt = S_DONE;
      end
      S_DONE, S_IDLE: begin
        done = (r_state == S_DONE);
        if (start) w_state_nxt = w_is_mul ? S_MUL : S_DONE;
        else       w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags     <= '0;
      r_result    <= '0;
      r_result_we <= 1'b0;
      r_product   <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_cnt       <= '0;
      r_s         <= 1'b0;
    end else begin
      case (r_state)
        S_MUL: begin
          r_product <= w_prod_nxt;
          r_mcand   <= r_mcand << 1;
          r_mplier  <= r_mplier >> 1;
          r_cnt     <= r_cnt - CW'(1);
          if (w_mul_last) begin
            r_result    <= w_prod_nxt;
            r_result_we <= 1'b1;
            if (r_s) r_flags <= {w_prod_nxt[W-1], (w_prod_nxt == '0), r_flags[1:0]};
          end
        end
        default: begin
          if (start) begin
            if (w_is_mul) begin
              r_product <= (op == c_OP_MLA) ? acc : '0;
              r_mcand   <= a;
              r_mplier  <= b;
              r_cnt     <= CW'(W);
              r_s       <= s;
            end else begin
              r_result    <= w_alu_res;
              r_result_we <= ~w_test;
              if (w_alu_setf) r_flags <= w_alu_flags;
            end
          end
        end
      endcase
      // Direct flag load overrides any simultaneous computed update.
      if (flags_wr) r_flags <= flags_in;
    end
  end

  assign result    = r_result;
  assign result_we = r_result_we;
  assign flags     = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_arm_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_arm_alu_seq
// Description : Self-checking bench for arm_alu_seq (W=32 and W=8 instances).
//               Directed vectors push expected responses into per-instance
//               queues; monitors pop and compare on every done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arm_alu_seq;

  typedef struct {
    logic [31:0] res;
    logic        we;
    logic [3:0]  fl;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;

  logic        start, s, flags_wr;
  logic [4:0]  op;
  logic [31:0] a, b, acc;
  logic [3:0]  flags_in;
  logic        busy, done, result_we;
  logic [31:0] result;
  logic [3:0]  flags;

  logic        start8, s8, flags_wr8;
  logic [4:0]  op8;
  logic [7:0]  a8, b8, acc8;
  logic [3:0]  flags_in8;
  logic        busy8, done8, result_we8;
  logic [7:0]  result8;
  logic [3:0]  flags8;

  exp_t q32[$];
  exp_t q8[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  arm_alu_seq #(.W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .acc(acc),
    .s(s), .flags_wr(flags_wr), .flags_in(flags_in), .busy(busy), .done(done),
    .result(result), .result_we(result_we), .flags(flags)
  );

  arm_alu_seq #(.W(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8), .acc(acc8),
    .s(s8), .flags_wr(flags_wr8), .flags_in(flags_in8), .busy(busy8), .done(done8),
    .result(result8), .result_we(result_we8), .flags(flags8)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    n_checks++;
    if (act !== ex) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, ex);
    end
  endtask

  // Monitors: compare against the oldest outstanding expectation on done.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (done === 1'b1) begin
      if (q32.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL done32_unexpected: got done=1 expected no completion");
      end else begin
        e = q32.pop_front();
        chk("w32_result_we", {31'd0, result_we}, {31'd0, e.we});
        if (e.we) chk("w32_result", result, e.res);
        chk("w32_flags", {28'd0, flags}, {28'd0, e.fl});
      end
    end
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (done8 === 1'b1) begin
      if (q8.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL done8_unexpected: got done=1 expected no completion");
      end else begin
        e = q8.pop_front();
        chk("w8_result_we", {31'd0, result_we8}, {31'd0, e.we});
        if (e.we) chk("w8_result", {24'd0, result8}, e.res);
        chk("w8_flags", {28'd0, flags8}, {28'd0, e.fl});
      end
    end
  end

  // Issue one op on the W=32 instance, optionally pulsing a stray start
  // after edge inj (while busy), and check the edge count to done.
  task automatic run(input logic [4:0] o, input logic [31:0] av, input logic [31:0] bv,
                     input logic [31:0] accv, input logic sv, input logic [31:0] er,
                     input logic ewe, input logic [3:0] ef, input int lat, input int inj);
    exp_t e;
    int   edges;
    bit   seen;
    @(negedge clk);
    op = o; a = av; b = bv; acc = accv; s = sv; start = 1'b1;
    e.res = er; e.we = ewe; e.fl = ef;
    q32.push_back(e);
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < lat + 4) begin
      @(posedge clk);
      #1;
      edges++;
      if (done === 1'b1) seen = 1'b1;
      else begin
        @(negedge clk);
        if (edges == inj) begin
          chk("busy_during_mul", {31'd0, busy}, 32'd1);
          start = 1'b1; op = 5'b00100; a = 32'd1; b = 32'd1;
        end else begin
          start = 1'b0;
        end
      end
    end
    @(negedge clk);
    start = 1'b0;
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL w32_timeout op=%b: got no done expected done after %0d edges", o, lat);
    end else begin
      chk("w32_latency", edges, lat);
    end
  endtask

  task automatic run8(input logic [4:0] o, input logic [7:0] av, input logic [7:0] bv,
                      input logic sv, input logic [7:0] er, input logic [3:0] ef,
                      input int lat);
    exp_t e;
    int   edges;
    bit   seen;
    @(negedge clk);
    op8 = o; a8 = av; b8 = bv; acc8 = 8'd0; s8 = sv; start8 = 1'b1;
    e.res = {24'd0, er}; e.we = 1'b1; e.fl = ef;
    q8.push_back(e);
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < lat + 4) begin
      @(posedge clk);
      #1;
      edges++;
      if (done8 === 1'b1) seen = 1'b1;
      else begin
        @(negedge clk);
        start8 = 1'b0;
      end
    end
    @(negedge clk);
    start8 = 1'b0;
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL w8_timeout op=%b: got no done expected done after %0d edges", o, lat);
    end else begin
      chk("w8_latency", edges, lat);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0; op = '0; a = '0; b = '0; acc = '0; s = 1'b0;
    flags_wr = 1'b0; flags_in = '0;
    start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0; acc8 = '0; s8 = 1'b0;
    flags_wr8 = 1'b0; flags_in8 = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_done",      {31'd0, done},      32'd0);
    chk("rst_result",    result,             32'd0);
    chk("rst_result_we", {31'd0, result_we}, 32'd0);
    chk("rst_flags",     {28'd0, flags},     32'd0);
    chk("rst8_result",   {24'd0, result8},   32'd0);
    chk("rst8_flags",    {28'd0, flags8},    32'd0);
    reset = 1'b0;

    //   op        a             b             acc           s     result        we    NZCV     lat inj
    run(5'b00100, 32'hFFFFFFFF, 32'h00000001, 32'h0,        1'b1, 32'h00000000, 1'b1, 4'b0110, 1,  -1); // ADD
    run(5'b00010, 32'd5,        32'd7,        32'h0,        1'b1, 32'hFFFFFFFE, 1'b1, 4'b1000, 1,  -1); // SUB
    run(5'b01010, 32'd7,        32'd7,        32'h0,        1'b0, 32'h00000000, 1'b0, 4'b0110, 1,  -1); // CMP

    @(negedge clk);
    flags_wr = 1'b1; flags_in = 4'b0010;
    @(negedge clk);
    flags_wr = 1'b0;
    chk("flags_wr_load", {28'd0, flags}, 32'h2);

    run(5'b00101, 32'h7FFFFFFF, 32'h0,        32'h0,        1'b1, 32'h80000000, 1'b1, 4'b1001, 1,  -1); // ADC
    run(5'b10010, 32'h00010000, 32'h00010000, 32'h0,        1'b1, 32'h00000000, 1'b1, 4'b0101, 33, 5);  // MUL
    run(5'b10011, 32'd3,        32'd4,        32'd5,        1'b0, 32'd17,       1'b1, 4'b0101, 33, -1); // MLA

    // Second MLA aborted by an asynchronous reset partway through.
    @(negedge clk);
    op = 5'b10011; a = 32'd9; b = 32'd9; acc = 32'd1; s = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("mla_busy_before_abort", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy",   {31'd0, busy},  32'd0);
    chk("abort_done",   {31'd0, done},  32'd0);
    chk("abort_result", result,         32'd0);
    chk("abort_flags",  {28'd0, flags}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run(5'b10011, 32'h40000000, 32'd2,        32'd1,        1'b1, 32'h80000001, 1'b1, 4'b1000, 33, -1); // MLA
    run(5'b00110, 32'd10,       32'd3,        32'h0,        1'b1, 32'd6,        1'b1, 4'b0010, 1,  -1); // SBC
    run(5'b01111, 32'h0,        32'h0,        32'h0,        1'b0, 32'hFFFFFFFF, 1'b1, 4'b0010, 1,  -1); // MVN
    run(5'b01000, 32'h000000F0, 32'h0000000F, 32'h0,        1'b0, 32'h00000000, 1'b0, 4'b0110, 1,  -1); // TST
    run(5'b11111, 32'h0,        32'h00001234, 32'h0,        1'b1, 32'h00001234, 1'b1, 4'b0110, 1,  -1); // undefined
    run(5'b01110, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0,        1'b1, 32'hF000F000, 1'b1, 4'b1010, 1,  -1); // BIC
    run(5'b00011, 32'd1,        32'd0,        32'h0,        1'b1, 32'hFFFFFFFF, 1'b1, 4'b1000, 1,  -1); // RSB
    run(5'b10001, 32'h7FFFFFFF, 32'h0,        32'h0,        1'b1, 32'h80000000, 1'b1, 4'b1001, 1,  -1); // INC

    run8(5'b00100, 8'h80, 8'h80, 1'b1, 8'h00, 4'b0111, 1); // ADD, W=8
    run8(5'b10010, 8'h0F, 8'h11, 1'b0, 8'hFF, 4'b0111, 9); // MUL, W=8

    repeat (3) @(negedge clk);
    chk("q32_drained", q32.size(), 32'd0);
    chk("q8_drained",  q8.size(),  32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
